// File: rtl/dsdmnist_macacc.sv
// dsdmnist_macacc
// Signed int8 dot-product accumulator for one output neuron. It takes VECLEN
// activation/weight pairs and forms their products. The products are summed in
// a 25-bit two's-complement accumulator. The finished sum is presented with a
// one-cycle load strobe for the post-calculation stage.
//
// Ports:
//   i_CLK        clock, rising edge
//   i_RST_n      asynchronous active-low reset
//   i_START      begin a new dot product (honoured only in IDLE)
//   i_DIN_VALID  i_ACT/i_WGT hold a valid pair (honoured only in RUN)
//   i_ACT        signed activation
//   i_WGT        signed weight
//   o_BUSY       high while a dot product is in progress
//   o_ACCVAL_LD  one-cycle strobe: o_ACCVAL holds a completed sum
//   o_ACCVAL     signed sum, held between strobes
module dsdmnist_macacc #(
  parameter int VECLEN = 784,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8
) (
  input  logic              i_CLK,
  input  logic              i_RST_n,
  input  logic              i_START,
  input  logic              i_DIN_VALID,
  input  logic [DATA_W-1:0] i_ACT,
  input  logic [COEF_W-1:0] i_WGT,
  output logic              o_BUSY,
  output logic              o_ACCVAL_LD,
  output logic [24:0]       o_ACCVAL
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = 25;
  localparam int CNT_W  = 10;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VECLEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    EMIT  = 2'd3
  } state_t;

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic signed [DATA_W-1:0]  act_p0;
  logic signed [COEF_W-1:0]  wgt_p0;
  logic signed [PROD_W-1:0]  prod_p0;
  logic signed [PROD_W-1:0]  prod_p1;
  logic                      vld_p1;
  logic signed [ACC_W-1:0]   acc_p2;

  // Sign-extend a product to the accumulator width.
  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  // ---- stage p0: combinational signed multiply of the incoming pair ----
  assign act_p0  = i_ACT;
  assign wgt_p0  = i_WGT;
  assign prod_p0 = act_p0 * wgt_p0;

  // ---- stage p1: control FSM, pair counter, product register, output register ----
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state       <= IDLE;
      cnt         <= '0;
      prod_p1     <= '0;
      vld_p1      <= 1'b0;
      o_BUSY      <= 1'b0;
      o_ACCVAL_LD <= 1'b0;
      o_ACCVAL    <= '0;
    end else begin
      // Product-valid and the strobe are one-cycle pulses unless re-asserted.
      vld_p1      <= 1'b0;
      o_ACCVAL_LD <= 1'b0;
      case (state)
        IDLE: begin
          if (i_START) begin
            state  <= RUN;
            cnt    <= '0;
            o_BUSY <= 1'b1;
          end
        end
        RUN: begin
          if (i_DIN_VALID) begin
            prod_p1 <= prod_p0;
            vld_p1  <= 1'b1;
            cnt     <= cnt + 1'b1;
            if (cnt == LAST_IDX) begin
              state <= DRAIN;
            end
          end
        end
        // The accumulator absorbs the final product on this edge.
        DRAIN: begin
          state <= EMIT;
        end
        EMIT: begin
          o_ACCVAL    <= acc_p2;
          o_ACCVAL_LD <= 1'b1;
          o_BUSY      <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ---- stage p2: accumulator, cleared when a new run is accepted ----
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      acc_p2 <= '0;
    end else if ((state == IDLE) && i_START) begin
      acc_p2 <= '0;
    end else if (vld_p1) begin
      acc_p2 <= acc_p2 + sext_prod(prod_p1);
    end
  end

endmodule

// File: tb/tb_dsdmnist_macacc.sv
// Testbench for dsdmnist_macacc: scoreboard of expected sums and strobe cycles,
// plus a small directed sequence on a VECLEN=1 instance.
module tb_dsdmnist_macacc;

  localparam int VECLEN = 784;

  logic        clk;
  logic        rst_n;
  logic        start, din_valid;
  logic [7:0]  act, wgt;
  logic        busy, ld;
  logic [24:0] accval;

  logic        start1, vld1;
  logic [7:0]  act1, wgt1;
  logic        busy1, ld1;
  logic [24:0] accval1;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [24:0] exp_q[$];
  int          cyc_q[$];

  dsdmnist_macacc #(.VECLEN(VECLEN)) u_dut (
    .i_CLK(clk), .i_RST_n(rst_n), .i_START(start), .i_DIN_VALID(din_valid),
    .i_ACT(act), .i_WGT(wgt), .o_BUSY(busy), .o_ACCVAL_LD(ld), .o_ACCVAL(accval)
  );

  dsdmnist_macacc #(.VECLEN(1)) u_dut1 (
    .i_CLK(clk), .i_RST_n(rst_n), .i_START(start1), .i_DIN_VALID(vld1),
    .i_ACT(act1), .i_WGT(wgt1), .o_BUSY(busy1), .o_ACCVAL_LD(ld1), .o_ACCVAL(accval1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest expected sum and cycle.
  always @(negedge clk) begin
    if (rst_n && ld) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ld", {31'd0, ld}, 32'd0);
      end else begin
        logic [24:0] e;
        int          ec;
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        chk("accval", {7'd0, accval}, {7'd0, e});
        chk("ld_cycle", cyc, ec);
        chk("busy_at_ld", {31'd0, busy}, 32'd0);
      end
    end
  end

  // kind: 0 = 1*1, 1 = -128*-128, 2 = -128*127, 3 = random, 4 = 1*-1
  task automatic do_run(input int kind, input int bubble_pct);
    int  n;
    int  sum;
    byte a, w;
    n   = 0;
    sum = 0;
    @(posedge clk); #1;
    start = 1'b1; din_valid = 1'b1; act = 8'h7f; wgt = 8'h7f;  // not a pair
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_rise", {31'd0, busy}, 32'd1);
    while (n < VECLEN) begin
      if (int'($urandom_range(99)) < bubble_pct) begin
        din_valid = 1'b0; act = 8'($urandom); wgt = 8'($urandom);
      end else begin
        case (kind)
          0:       begin a = 8'sd1;    w = 8'sd1;    end
          1:       begin a = -8'sd128; w = -8'sd128; end
          2:       begin a = -8'sd128; w = 8'sd127;  end
          4:       begin a = 8'sd1;    w = -8'sd1;   end
          default: begin a = byte'($urandom); w = byte'($urandom); end
        endcase
        din_valid = 1'b1; act = a; wgt = w;
        sum += int'(a) * int'(w);
        n++;
        if (n == VECLEN) begin
          exp_q.push_back(25'(sum));
          cyc_q.push_back(cyc + 3);
        end
      end
      @(posedge clk); #1;
    end
    // Pairs offered during DRAIN and EMIT must be dropped.
    din_valid = 1'b1; act = 8'h80; wgt = 8'h80;
    chk("busy_mid", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("busy_drain", {31'd0, busy}, 32'd1);
    act = 8'h7f; wgt = 8'h80;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start = 1'b0; din_valid = 1'b1; act = 8'($urandom); wgt = 8'($urandom);
    end
  endtask

  task automatic aborted_run();
    @(posedge clk); #1;
    start = 1'b1; din_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      din_valid = 1'b1; act = 8'($urandom); wgt = 8'($urandom);
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_accval", {7'd0, accval}, 32'd0);
    chk("rst_ld", {31'd0, ld}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    din_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; din_valid = 1'b0; act = '0; wgt = '0;
    start1 = 1'b0; vld1 = 1'b0; act1 = '0; wgt1 = '0;
    #1;
    chk("reset_accval", {7'd0, accval}, 32'd0);
    chk("reset_ld", {31'd0, ld}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    do_run(0, 0);             // 784
    idle_cycles(3);
    do_run(1, 0);             // 12845056
    idle_cycles(2);
    do_run(2, 0);             // -12744704
    idle_cycles(4);
    do_run(3, 50);            // random with bubbles
    idle_cycles(2);
    do_run(0, 0);             // back-to-back: +784 ...
    do_run(4, 0);             // ... then -784 started in the strobe cycle
    idle_cycles(3);
    aborted_run();
    idle_cycles(3);
    do_run(3, 30);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("sb_empty", exp_q.size(), 32'd0);

    // VECLEN = 1: first valid pair goes straight to DRAIN.
    @(posedge clk); #1;
    start1 = 1'b1; vld1 = 1'b1; act1 = 8'd100; wgt1 = 8'd100;  // not a pair
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("v1_busy_rise", {31'd0, busy1}, 32'd1);
    vld1 = 1'b1; act1 = 8'd5; wgt1 = 8'hF9;                    // 5 * -7
    @(posedge clk); #1;
    chk("v1_ld_e", {31'd0, ld1}, 32'd0);
    act1 = 8'd100; wgt1 = 8'd100;                              // DRAIN: dropped
    @(posedge clk); #1;
    chk("v1_ld_e1", {31'd0, ld1}, 32'd0);
    vld1 = 1'b0;
    @(posedge clk); #1;
    chk("v1_ld_e2", {31'd0, ld1}, 32'd1);
    chk("v1_accval", {7'd0, accval1}, {7'd0, 25'h1FFFFDD});
    chk("v1_busy_fall", {31'd0, busy1}, 32'd0);
    @(posedge clk); #1;
    chk("v1_ld_e3", {31'd0, ld1}, 32'd0);
    chk("v1_accval_hold", {7'd0, accval1}, {7'd0, 25'h1FFFFDD});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
